// File: rtl/mod_updown_counter_if.sv
// Control and status bundle for mod_updown_counter; master drives the
// controls, slave (the counter) drives count and status flags.
interface mod_updown_counter_if #(
  parameter int WIDTH = 6
);
  logic             clear;
  logic             enable;
  logic             forward;
  logic             tick;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] out;
  logic             carry;
  logic             finish;
  logic             at_zero;
  logic             at_max;

  modport master (
    output clear, enable, forward, tick, load, load_value,
    input  out, carry, finish, at_zero, at_max
  );

  modport slave (
    input  clear, enable, forward, tick, load, load_value,
    output out, carry, finish, at_zero, at_max
  );
endinterface

// File: rtl/mod_updown_counter.sv
// Modulo-N up/down counter stepping once per tick rising edge; count and carry
// update on the edge that samples the tick edge; no backpressure.
module mod_updown_counter #(
  parameter int WIDTH   = 6,
  parameter int MODULUS = 60,
  parameter int WRAP    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  mod_updown_counter_if.slave  bus
);

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);

  logic             r_tick_q;
  logic [WIDTH-1:0] r_cnt;
  logic             r_carry;
  logic             r_finish;

  logic             w_step;
  logic [WIDTH-1:0] w_cnt_nxt;
  logic             w_carry_nxt;
  logic             w_finish_nxt;

  // tick_q tracks tick regardless of enable, so a tick already high when
  // enable rises is not mistaken for a fresh edge.
  assign w_step = bus.enable & bus.tick & ~r_tick_q;

  always_comb begin
    w_cnt_nxt    = r_cnt;
    w_carry_nxt  = 1'b0;
    w_finish_nxt = r_finish;
    if (bus.clear) begin
      w_cnt_nxt    = '0;
      w_finish_nxt = 1'b0;
    end else if (bus.enable && bus.load) begin
      w_cnt_nxt    = (bus.load_value > MAXV) ? MAXV : bus.load_value;
      w_finish_nxt = 1'b0;
    end else if (w_step) begin
      if (bus.forward) begin
        if (r_cnt != MAXV) begin
          w_cnt_nxt = r_cnt + WIDTH'(1);
        end else if (WRAP != 0) begin
          w_cnt_nxt   = '0;
          w_carry_nxt = 1'b1;
        end
      end else begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - WIDTH'(1);
        end else begin
          w_finish_nxt = 1'b1;
          if (WRAP != 0) begin
            w_cnt_nxt   = MAXV;
            w_carry_nxt = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tick_q <= 1'b0;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_finish <= 1'b0;
    end else begin
      r_tick_q <= bus.tick;
      r_cnt    <= w_cnt_nxt;
      r_carry  <= w_carry_nxt;
      r_finish <= w_finish_nxt;
    end
  end

  assign bus.out     = r_cnt;
  assign bus.carry   = r_carry;
  assign bus.finish  = r_finish;
  assign bus.at_zero = (r_cnt == '0);
  assign bus.at_max  = (r_cnt == MAXV);

endmodule
